// File: rtl/meas_window_ctl.sv
// -----------------------------------------------------------------------------
// meas_window_ctl
//
// Measurement-window controller. Sits inline on a 134-bit control-flit path,
// terminates register reads/writes addressed to its own module ID (LMID) and
// forwards every other flit with one cycle of registered latency. A small FSM
// (IDLE -> RUN -> DRAIN -> CLR) opens a measurement window, drains it, and
// pulses a one-cycle statistics clear at the end of every window.
//
// Optional feature macro: MWC_PKT_LIMIT_EN
//   defined   : PKT_MAX register (0x60000003) exists and a window also ends
//               when the packet count reaches a nonzero PKT_MAX (cause 10).
//   undefined : writes to 0x60000003 are dropped, reads return 0, and windows
//               end only by timer or abort.
//
// Ports
//   clk               in   1    sole clock
//   rst_n             in   1    asynchronous active-low reset
//   cin_mwc_data      in   134  control flit from upstream
//   cin_mwc_data_wr   in   1    upstream flit valid
//   cout_mwc_ready    out  1    ready to upstream (mirrors cin_mwc_ready)
//   cout_mwc_data     out  134  forwarded / response flit
//   cout_mwc_data_wr  out  1    downstream flit valid
//   cin_mwc_ready     in   1    downstream ready
//   in_pkt_wr         in   1    one pulse per metadata word accepted
//   out_sent_start    out  1    high while the window is open (RUN)
//   out_sent_end      out  1    high while the window drains (DRAIN)
//   out_stat_reset    out  1    one-cycle statistics clear (CLR)
//   out_busy          out  1    high whenever the FSM is not IDLE
//
// Register map
//   0x60000000 CTRL      bit0 ARM, bit1 CONT
//   0x60000001 WIN_LEN   window length in cycles
//   0x60000002 DRAIN_LEN drain length in cycles (0 behaves as 1)
//   0x60000003 PKT_MAX   packet limit (0 = no limit)
//   0x60000008 STATUS    {state[18:16], cause[15:14], epoch[13:0]} (read only)
//   0x60000009 PKT_CNT   packets counted in the current/last window (read only)
// -----------------------------------------------------------------------------
module meas_window_ctl #(
  parameter logic [7:0] LMID = 8'd6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] cin_mwc_data,
  input  logic         cin_mwc_data_wr,
  output logic         cout_mwc_ready,
  output logic [133:0] cout_mwc_data,
  output logic         cout_mwc_data_wr,
  input  logic         cin_mwc_ready,
  input  logic         in_pkt_wr,
  output logic         out_sent_start,
  output logic         out_sent_end,
  output logic         out_stat_reset,
  output logic         out_busy
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0]  FLIT_HDR     = 2'b01;
  localparam logic [2:0]  OP_WR        = 3'b010;
  localparam logic [2:0]  OP_RD        = 3'b001;
  localparam logic [3:0]  RSP_OP       = 4'b1011;

  localparam logic [31:0] ADDR_CTRL    = 32'h6000_0000;
  localparam logic [31:0] ADDR_WIN     = 32'h6000_0001;
  localparam logic [31:0] ADDR_DRAIN   = 32'h6000_0002;
  localparam logic [31:0] ADDR_PKT_MAX = 32'h6000_0003;
  localparam logic [31:0] ADDR_STATUS  = 32'h6000_0008;
  localparam logic [31:0] ADDR_PKT_CNT = 32'h6000_0009;

  localparam logic [1:0]  CAUSE_TIMER  = 2'b01;
  localparam logic [1:0]  CAUSE_LIMIT  = 2'b10;
  localparam logic [1:0]  CAUSE_ABORT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CLR   = 3'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Flit path
  logic [133:0] r_out_data;
  logic         r_out_wr;
  logic         r_consume;     // drop the tail that follows a local write

  // Software-visible registers
  logic         r_arm;
  logic         r_cont;
  logic [31:0]  r_win_len;
  logic [31:0]  r_drain_len;

  // Window engine
  state_t       r_state;
  logic [31:0]  r_win_lat;     // window parameters frozen at RUN entry
  logic [31:0]  r_drain_lat;
  logic [31:0]  r_timer;
  logic [31:0]  r_pkt_cnt;
  logic [13:0]  r_epoch;
  logic [1:0]   r_cause;
  logic         r_sent_start;
  logic         r_sent_end;
  logic         r_stat_reset;
  logic         r_busy;

`ifdef MWC_PKT_LIMIT_EN
  logic [31:0]  r_pkt_max;
  logic [31:0]  r_pmax_lat;
`endif

  // ---------------------------------------------------------------------------
  // Flit field decode
  // ---------------------------------------------------------------------------
  logic [1:0]   w_flit_type;
  logic [2:0]   w_op;
  logic [7:0]   w_src;
  logic [7:0]   w_dst;
  logic [31:0]  w_addr;
  logic [31:0]  w_wdata;
  logic         w_local_hdr;
  logic         w_local_wr;
  logic         w_local_rd;
  logic         w_arm_clr_wr;
  logic [31:0]  w_rd_data;
  logic [133:0] w_rsp;

  assign w_flit_type = cin_mwc_data[133:132];
  assign w_op        = cin_mwc_data[126:124];
  assign w_src       = cin_mwc_data[111:104];
  assign w_dst       = cin_mwc_data[103:96];
  assign w_addr      = cin_mwc_data[95:64];
  assign w_wdata     = cin_mwc_data[31:0];

  // A flit arriving while r_consume is set is the tail of a local write and is
  // never decoded as a new header.
  assign w_local_hdr = cin_mwc_data_wr && !r_consume &&
                       (w_flit_type == FLIT_HDR) && (w_dst == LMID);
  assign w_local_wr  = w_local_hdr && (w_op == OP_WR) && cin_mwc_ready;
  assign w_local_rd  = w_local_hdr && (w_op == OP_RD);

  // Software clearing ARM: aborts an open window and blocks any RUN entry
  // evaluated in the same cycle.
  assign w_arm_clr_wr = w_local_wr && (w_addr == ADDR_CTRL) && !w_wdata[0];

  // Read-data mux
  always_comb begin
    // NOTE: default assignment first so every path drives w_rd_data and no latch is inferred.
    w_rd_data = '0;
    case (w_addr)
      ADDR_CTRL:    w_rd_data = {30'd0, r_cont, r_arm};
      ADDR_WIN:     w_rd_data = r_win_len;
      ADDR_DRAIN:   w_rd_data = r_drain_len;
`ifdef MWC_PKT_LIMIT_EN
      ADDR_PKT_MAX: w_rd_data = r_pkt_max;
`endif
      ADDR_STATUS:  w_rd_data = {13'd0, 3'(r_state), r_cause, r_epoch};
      ADDR_PKT_CNT: w_rd_data = r_pkt_cnt;
      default:      w_rd_data = '0;
    endcase
  end

  // Read response: new opcode, src/dst swapped, payload replaced, rest intact.
  assign w_rsp = {cin_mwc_data[133:128], RSP_OP, cin_mwc_data[123:112],
                  w_dst, w_src, cin_mwc_data[95:32], w_rd_data};

  // ---------------------------------------------------------------------------
  // Flit path: 1-cycle registered forward / response / consume
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_wr   <= 1'b0;
      r_consume  <= 1'b0;
    end else begin
      r_out_data <= '0;
      r_out_wr   <= 1'b0;
      if (cin_mwc_data_wr) begin
        if (r_consume) begin
          r_consume <= 1'b0;
        end else if (w_local_wr) begin
          r_consume <= 1'b1;
        end else if (w_local_rd) begin
          r_out_wr   <= 1'b1;
          r_out_data <= w_rsp;
        end else begin
          r_out_wr   <= 1'b1;
          r_out_data <= cin_mwc_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window engine helpers
  // ---------------------------------------------------------------------------
  logic [31:0] w_timer_inc;
  logic [31:0] w_pkt_cnt_inc;
  logic        w_limit_hit;
  logic        w_enter_run;

  assign w_timer_inc   = r_timer + 32'd1;
  assign w_pkt_cnt_inc = (r_pkt_cnt == '1) ? r_pkt_cnt
                                           : r_pkt_cnt + {31'd0, in_pkt_wr};

`ifdef MWC_PKT_LIMIT_EN
  assign w_limit_hit = (r_pmax_lat != '0) && (w_pkt_cnt_inc >= r_pmax_lat);
`else
  assign w_limit_hit = 1'b0;
`endif

  // RUN is entered from IDLE when armed, or straight from CLR in continuous
  // mode. A zero WIN_LEN never opens a window.
  assign w_enter_run = r_arm && !w_arm_clr_wr && (r_win_len != '0) &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_CLR) && r_cont));

  // ---------------------------------------------------------------------------
  // Registers + FSM (single block: ARM is written by software and by the FSM)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is a plain flop with a reset value; there is
      // no RAM in this block, so nothing is deliberately left unreset.
      r_arm        <= 1'b0;
      r_cont       <= 1'b0;
      r_win_len    <= '0;
      r_drain_len  <= '0;
      r_state      <= ST_IDLE;
      r_win_lat    <= '0;
      r_drain_lat  <= '0;
      r_timer      <= '0;
      r_pkt_cnt    <= '0;
      r_epoch      <= '0;
      r_cause      <= '0;
      r_sent_start <= 1'b0;
      r_sent_end   <= 1'b0;
      r_stat_reset <= 1'b0;
      r_busy       <= 1'b0;
`ifdef MWC_PKT_LIMIT_EN
      r_pkt_max    <= '0;
      r_pmax_lat   <= '0;
`endif
    end else begin
      // Software register writes (live copies; windows use latched copies)
      if (w_local_wr) begin
        case (w_addr)
          ADDR_CTRL: begin
            r_arm  <= w_wdata[0];
            r_cont <= w_wdata[1];
          end
          ADDR_WIN:     r_win_len   <= w_wdata;
          ADDR_DRAIN:   r_drain_len <= w_wdata;
`ifdef MWC_PKT_LIMIT_EN
          ADDR_PKT_MAX: r_pkt_max   <= w_wdata;
`endif
          default: ;
        endcase
      end

      if ((r_state == ST_RUN) || (r_state == ST_DRAIN)) begin
        r_pkt_cnt <= w_pkt_cnt_inc;
      end

      case (r_state)
        ST_IDLE: ;  // leaving IDLE is handled by w_enter_run below

        ST_RUN: begin
          // Priority: abort > timer > packet limit
          if (w_arm_clr_wr || (w_timer_inc >= r_win_lat) || w_limit_hit) begin
            r_state      <= ST_DRAIN;
            r_timer      <= '0;
            r_sent_start <= 1'b0;
            r_sent_end   <= 1'b1;
            if (w_arm_clr_wr) begin
              r_cause <= CAUSE_ABORT;
            end else if (w_timer_inc >= r_win_lat) begin
              r_cause <= CAUSE_TIMER;
            end else begin
              r_cause <= CAUSE_LIMIT;
            end
          end else begin
            r_timer <= w_timer_inc;
          end
        end

        ST_DRAIN: begin
          // A zero DRAIN_LEN still gives one drain cycle.
          if (w_timer_inc >= r_drain_lat) begin
            r_state      <= ST_CLR;
            r_sent_end   <= 1'b0;
            r_stat_reset <= 1'b1;
          end else begin
            r_timer <= w_timer_inc;
          end
        end

        ST_CLR: begin
          r_epoch      <= r_epoch + 14'd1;
          r_stat_reset <= 1'b0;
          if (!w_enter_run) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_arm   <= 1'b0;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_sent_start <= 1'b0;
          r_sent_end   <= 1'b0;
          r_stat_reset <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase

      // Window open: freeze parameters, clear timer and packet count.
      if (w_enter_run) begin
        r_state      <= ST_RUN;
        r_sent_start <= 1'b1;
        r_busy       <= 1'b1;
        r_timer      <= '0;
        r_pkt_cnt    <= '0;
        r_win_lat    <= r_win_len;
        r_drain_lat  <= r_drain_len;
`ifdef MWC_PKT_LIMIT_EN
        r_pmax_lat   <= r_pkt_max;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Ready is a straight pass-through, forced low while reset is held so that
  // every output reads 0 during reset.
  assign cout_mwc_ready   = cin_mwc_ready && rst_n;
  assign cout_mwc_data    = r_out_data;
  assign cout_mwc_data_wr = r_out_wr;
  assign out_sent_start   = r_sent_start;
  assign out_sent_end     = r_sent_end;
  assign out_stat_reset   = r_stat_reset;
  assign out_busy         = r_busy;

endmodule

// File: tb/tb_meas_window_ctl.sv
// -----------------------------------------------------------------------------
// tb_meas_window_ctl
//
// Directed testbench for meas_window_ctl. Inputs are driven just after the
// falling edge and outputs are sampled on the following falling edge, i.e.
// after the rising edge that consumed the inputs.
// Follows the MWC_PKT_LIMIT_EN define of the build for limit-dependent values.
// -----------------------------------------------------------------------------
module tb_meas_window_ctl;

  localparam logic [31:0] ADDR_CTRL    = 32'h6000_0000;
  localparam logic [31:0] ADDR_WIN     = 32'h6000_0001;
  localparam logic [31:0] ADDR_DRAIN   = 32'h6000_0002;
  localparam logic [31:0] ADDR_PKT_MAX = 32'h6000_0003;
  localparam logic [31:0] ADDR_UNUSED  = 32'h6000_0005;
  localparam logic [31:0] ADDR_STATUS  = 32'h6000_0008;
  localparam logic [31:0] ADDR_PKT_CNT = 32'h6000_0009;

`ifdef MWC_PKT_LIMIT_EN
  localparam int          EXP_LIM_START   = 3;
  localparam logic [31:0] EXP_LIM_PKT_CNT = 32'd4;    // 3 in RUN + 1 in DRAIN
  localparam logic [31:0] EXP_LIM_STATUS  = 32'h0000_8005;
  localparam logic [31:0] EXP_PKT_MAX     = 32'd3;
`else
  localparam int          EXP_LIM_START   = 100;
  localparam logic [31:0] EXP_LIM_PKT_CNT = 32'd101;  // 100 in RUN + 1 in DRAIN
  localparam logic [31:0] EXP_LIM_STATUS  = 32'h0000_4005;
  localparam logic [31:0] EXP_PKT_MAX     = 32'd0;
`endif

  logic         clk;
  logic         rst_n;
  logic [133:0] cin_mwc_data;
  logic         cin_mwc_data_wr;
  logic         cout_mwc_ready;
  logic [133:0] cout_mwc_data;
  logic         cout_mwc_data_wr;
  logic         cin_mwc_ready;
  logic         in_pkt_wr;
  logic         out_sent_start;
  logic         out_sent_end;
  logic         out_stat_reset;
  logic         out_busy;

  int n_tests = 0;
  int n_fail  = 0;

  meas_window_ctl #(.LMID(8'd6)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cin_mwc_data     (cin_mwc_data),
    .cin_mwc_data_wr  (cin_mwc_data_wr),
    .cout_mwc_ready   (cout_mwc_ready),
    .cout_mwc_data    (cout_mwc_data),
    .cout_mwc_data_wr (cout_mwc_data_wr),
    .cin_mwc_ready    (cin_mwc_ready),
    .in_pkt_wr        (in_pkt_wr),
    .out_sent_start   (out_sent_start),
    .out_sent_end     (out_sent_end),
    .out_stat_reset   (out_stat_reset),
    .out_busy         (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  function automatic logic [133:0] mk_hdr(input logic [3:0] op, input logic [7:0] src,
                                          input logic [7:0] dst, input logic [31:0] addr,
                                          input logic [31:0] data);
    logic [133:0] f;
    f = '0;
    f[133:132] = 2'b01;
    f[127:124] = op;
    f[111:104] = src;
    f[103:96]  = dst;
    f[95:64]   = addr;
    f[31:0]    = data;
    return f;
  endfunction

  function automatic logic [133:0] mk_tail(input logic [31:0] tag);
    logic [133:0] f;
    f = '0;
    f[133:132] = 2'b10;
    f[31:0]    = tag;
    return f;
  endfunction

  // Present one flit for one cycle; on return the registered result is visible.
  task automatic drive_flit(input logic [133:0] f);
    cin_mwc_data    = f;
    cin_mwc_data_wr = 1'b1;
    @(negedge clk);
    cin_mwc_data_wr = 1'b0;
    cin_mwc_data    = '0;
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
    drive_flit(mk_hdr(4'b0010, 8'h01, 8'h06, addr, data));
    drive_flit(mk_tail(32'h0));
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] val);
    drive_flit(mk_hdr(4'b0001, 8'h01, 8'h06, addr, 32'h0));
    val = cout_mwc_data[31:0];
    drive_flit(mk_tail(32'h0));
  endtask

  // Count phase cycles from now until out_busy drops, bounded by budget.
  task automatic measure(input int budget, output int n_s, output int n_e,
                         output int n_c, output bit timed_out);
    n_s = 0; n_e = 0; n_c = 0; timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      n_s += int'(out_sent_start);
      n_e += int'(out_sent_end);
      n_c += int'(out_stat_reset);
      if (!out_busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] v;
    rst_n           = 1'b0;
    cin_mwc_ready   = 1'b1;
    in_pkt_wr       = 1'b0;
    cin_mwc_data    = mk_tail(32'h1234_5678);
    cin_mwc_data_wr = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cout_mwc_ready, cout_mwc_data_wr, out_sent_start, out_sent_end,
         out_stat_reset, out_busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy/wr/st/en/clr/busy=%b want 000000",
               {cout_mwc_ready, cout_mwc_data_wr, out_sent_start, out_sent_end,
                out_stat_reset, out_busy});
    end
    n_tests++;
    if (cout_mwc_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", cout_mwc_data);
    end
    cin_mwc_data_wr = 1'b0;
    cin_mwc_data    = '0;
    rst_n           = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cout_mwc_ready !== 1'b1 || out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_ready: got rdy=%b busy=%b want rdy=1 busy=0",
               cout_mwc_ready, out_busy);
    end
    read_reg(ADDR_STATUS, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_status: got %h want 00000000", v);
    end
  endtask

  task automatic test_forward();
    logic [133:0] f;
    logic [31:0]  v;
    @(negedge clk);
    n_tests++;
    if (cout_mwc_data_wr !== 1'b0 || cout_mwc_data !== '0) begin
      n_fail++;
      $display("FAIL idle_output: got wr=%b data=%h want wr=0 data=0",
               cout_mwc_data_wr, cout_mwc_data);
    end
    // Write aimed at another module: forwarded, no register effect.
    f = mk_hdr(4'b0010, 8'h01, 8'h07, ADDR_WIN, 32'h0000_0055);
    f[123:112] = 12'h5A5;
    drive_flit(f);
    n_tests++;
    if (cout_mwc_data_wr !== 1'b1 || cout_mwc_data !== f) begin
      n_fail++;
      $display("FAIL fwd_foreign_hdr: got wr=%b data=%h want wr=1 data=%h",
               cout_mwc_data_wr, cout_mwc_data, f);
    end
    f = mk_tail(32'hCAFE_0001);
    f[131:128] = 4'h9;
    drive_flit(f);
    n_tests++;
    if (cout_mwc_data_wr !== 1'b1 || cout_mwc_data !== f) begin
      n_fail++;
      $display("FAIL fwd_foreign_tail: got wr=%b data=%h want wr=1 data=%h",
               cout_mwc_data_wr, cout_mwc_data, f);
    end
    read_reg(ADDR_WIN, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL foreign_write_ignored: got WIN_LEN=%h want 00000000", v);
    end
  endtask

  task automatic test_single_window();
    int n_s, n_e, n_c;
    bit to;
    logic [31:0] v;
    reg_write(ADDR_WIN, 32'd10);
    reg_write(ADDR_DRAIN, 32'd4);
    drive_flit(mk_hdr(4'b0010, 8'h01, 8'h06, ADDR_CTRL, 32'h1));
    n_tests++;
    if (cout_mwc_data_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL write_hdr_consumed: got wr=%b want 0", cout_mwc_data_wr);
    end
    drive_flit(mk_tail(32'h7777_7777));
    n_tests++;
    if (cout_mwc_data_wr !== 1'b0 || out_sent_start !== 1'b1) begin
      n_fail++;
      $display("FAIL write_tail_consumed_run: got wr=%b start=%b want wr=0 start=1",
               cout_mwc_data_wr, out_sent_start);
    end
    measure(100, n_s, n_e, n_c, to);
    n_tests++;
    if (to !== 1'b0 || n_s != 10 || n_e != 4 || n_c != 1) begin
      n_fail++;
      $display("FAIL single_window: got timeout=%0b start=%0d end=%0d clr=%0d want 0/10/4/1",
               to, n_s, n_e, n_c);
    end
    read_reg(ADDR_STATUS, v);
    n_tests++;
    if (v !== 32'h0000_4001) begin
      n_fail++;
      $display("FAIL single_status: got %h want 00004001", v);
    end
    read_reg(ADDR_CTRL, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL single_arm_cleared: got CTRL=%h want 00000000", v);
    end
  endtask

  task automatic test_continuous_abort();
    logic [2:0]  exp_v;
    logic [31:0] v;
    reg_write(ADDR_WIN, 32'd5);
    reg_write(ADDR_DRAIN, 32'd0);
    reg_write(ADDR_CTRL, 32'h3);
    // Two full periods: 5 cycles start, 1 cycle end, 1 cycle stat_reset.
    for (int i = 0; i < 14; i++) begin
      exp_v = ((i % 7) < 5) ? 3'b100 : (((i % 7) == 5) ? 3'b010 : 3'b001);
      n_tests++;
      if ({out_sent_start, out_sent_end, out_stat_reset} !== exp_v) begin
        n_fail++;
        $display("FAIL cont_cycle_%0d: got st/en/clr=%b want %b", i,
                 {out_sent_start, out_sent_end, out_stat_reset}, exp_v);
      end
      @(negedge clk);
    end
    // Third window just opened: clear ARM (keep CONT) on its first cycle.
    drive_flit(mk_hdr(4'b0010, 8'h01, 8'h06, ADDR_CTRL, 32'h2));
    n_tests++;
    if ({out_sent_start, out_sent_end, out_busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL abort_to_drain: got st/en/busy=%b want 011",
               {out_sent_start, out_sent_end, out_busy});
    end
    drive_flit(mk_tail(32'h0));
    n_tests++;
    if ({out_sent_end, out_stat_reset} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_clr: got en/clr=%b want 01", {out_sent_end, out_stat_reset});
    end
    @(negedge clk);
    n_tests++;
    if ({out_busy, out_sent_start, out_stat_reset} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_idle: got busy/st/clr=%b want 000",
               {out_busy, out_sent_start, out_stat_reset});
    end
    read_reg(ADDR_STATUS, v);
    n_tests++;
    if (v !== 32'h0000_C004) begin
      n_fail++;
      $display("FAIL abort_status: got %h want 0000c004", v);
    end
    read_reg(ADDR_CTRL, v);
    n_tests++;
    if (v !== 32'h2) begin
      n_fail++;
      $display("FAIL abort_ctrl: got %h want 00000002", v);
    end
  endtask

  task automatic test_pkt_limit();
    int n_s, n_e, n_c;
    bit to;
    logic [31:0] v;
    reg_write(ADDR_WIN, 32'd100);
    reg_write(ADDR_DRAIN, 32'd0);
    reg_write(ADDR_PKT_MAX, 32'd3);
    reg_write(ADDR_CTRL, 32'h1);
    in_pkt_wr = 1'b1;
    measure(300, n_s, n_e, n_c, to);
    in_pkt_wr = 1'b0;
    n_tests++;
    if (to !== 1'b0 || n_s != EXP_LIM_START || n_e != 1 || n_c != 1) begin
      n_fail++;
      $display("FAIL limit_window: got timeout=%0b start=%0d end=%0d clr=%0d want 0/%0d/1/1",
               to, n_s, n_e, n_c, EXP_LIM_START);
    end
    read_reg(ADDR_STATUS, v);
    n_tests++;
    if (v !== EXP_LIM_STATUS) begin
      n_fail++;
      $display("FAIL limit_status: got %h want %h", v, EXP_LIM_STATUS);
    end
    read_reg(ADDR_PKT_MAX, v);
    n_tests++;
    if (v !== EXP_PKT_MAX) begin
      n_fail++;
      $display("FAIL pkt_max_read: got %h want %h", v, EXP_PKT_MAX);
    end
  endtask

  task automatic test_read_response();
    logic [133:0] f;
    logic [133:0] exp_f;
    logic [31:0]  v;
    f = mk_hdr(4'b0001, 8'h01, 8'h06, ADDR_PKT_CNT, 32'h1234_5678);
    f[131:128] = 4'hA;
    f[123:112] = 12'hABC;
    f[63:32]   = 32'hDEAD_BEEF;
    exp_f = f;
    exp_f[127:124] = 4'b1011;
    exp_f[111:104] = 8'h06;
    exp_f[103:96]  = 8'h01;
    exp_f[31:0]    = EXP_LIM_PKT_CNT;
    drive_flit(f);
    n_tests++;
    if (cout_mwc_data_wr !== 1'b1 || cout_mwc_data !== exp_f) begin
      n_fail++;
      $display("FAIL read_response: got wr=%b data=%h want wr=1 data=%h",
               cout_mwc_data_wr, cout_mwc_data, exp_f);
    end
    f = mk_tail(32'h0BAD_F00D);
    f[131:128] = 4'h5;
    drive_flit(f);
    n_tests++;
    if (cout_mwc_data_wr !== 1'b1 || cout_mwc_data !== f) begin
      n_fail++;
      $display("FAIL read_tail_fwd: got wr=%b data=%h want wr=1 data=%h",
               cout_mwc_data_wr, cout_mwc_data, f);
    end
    read_reg(ADDR_UNUSED, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL unknown_addr_read: got %h want 00000000", v);
    end
  endtask

  task automatic test_reset_in_drain();
    logic [31:0] v;
    logic        seen_clr;
    reg_write(ADDR_WIN, 32'd3);
    reg_write(ADDR_DRAIN, 32'd10);
    reg_write(ADDR_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out_sent_start, out_sent_end} !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_before_reset: got st/en=%b want 01", {out_sent_start, out_sent_end});
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cout_mwc_ready, cout_mwc_data_wr, out_sent_start, out_sent_end,
         out_stat_reset, out_busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got rdy/wr/st/en/clr/busy=%b want 000000",
               {cout_mwc_ready, cout_mwc_data_wr, out_sent_start, out_sent_end,
                out_stat_reset, out_busy});
    end
    seen_clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_clr |= out_stat_reset;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen_clr |= out_stat_reset | out_busy;
    end
    n_tests++;
    if (seen_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL no_clr_after_reset: got stat_reset/busy seen=%b want 0", seen_clr);
    end
    read_reg(ADDR_STATUS, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_status_cleared: got %h want 00000000", v);
    end
    read_reg(ADDR_WIN, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_win_cleared: got %h want 00000000", v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n           = 1'b0;
    cin_mwc_data    = '0;
    cin_mwc_data_wr = 1'b0;
    cin_mwc_ready   = 1'b1;
    in_pkt_wr       = 1'b0;
    test_reset();
    test_forward();
    test_single_window();
    test_continuous_abort();
    test_pkt_limit();
    test_read_response();
    test_reset_in_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
